// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, NOP
// encoding, fetch FSM states and the {pc, instruction} record.
package fetch_stage_pkg;

  localparam int WORD = 32;

  localparam logic [WORD-1:0] NOP              = '0;
  localparam logic [WORD-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
    return {addr[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel, valid-only response.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imemReqValid;
  logic [WORD-1:0] imemReqAddr;
  logic            imemReqReady;
  logic            imemRespValid;
  logic [WORD-1:0] imemRespData;

  modport master (
    output imemReqValid, imemReqAddr,
    input  imemReqReady, imemRespValid, imemRespData
  );

  modport slave (
    input  imemReqValid, imemReqAddr,
    output imemReqReady, imemRespValid, imemRespData
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instruction} holding register that catches a fetch
// response arriving while the IF/ID register is stalled and full.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_drain,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)        r_full <= 1'b0;
    else if (i_clear) r_full <= 1'b0;
    else if (i_load)  r_full <= 1'b1;
    else if (i_drain) r_full <= 1'b0;
  end

  // NOTE: the payload is deliberately left out of reset; r_full qualifies it,
  // so resetting the data would only add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (i_load) r_entry <= i_entry;
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the fetch PC, issues one outstanding imem request at a
// time and fills the IF/ID register, honouring ID stalls and redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [WORD-1:0] redirectPC,
  input  logic            stallIF,
  fetch_stage_if.master   imem,
  output logic            idValid,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] instruction
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [WORD-1:0] r_fetch_pc;
  logic [WORD-1:0] r_req_pc;

  logic         w_handshake;
  logic         w_deliver;
  logic         w_skid_full;
  logic         w_skid_load;
  logic         w_skid_drain;
  fetch_entry_t w_skid_entry;

  assign w_handshake  = imem.imemReqValid && imem.imemReqReady;
  assign w_deliver    = (r_state == S_WAIT) && imem.imemRespValid && !redirect;
  // Only a stalled, occupied IF/ID pushes a response into the skid buffer.
  assign w_skid_load  = w_deliver && stallIF && idValid;
  assign w_skid_drain = !redirect && !stallIF && w_skid_full;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (redirect),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_entry ('{pc: r_req_pc, instr: imem.imemRespData}),
    .o_full  (w_skid_full),
    .o_entry (w_skid_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next_state;
  end

  // NOTE: always_comb blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_REQ:  if (w_handshake) w_next_state = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (redirect)                w_next_state = imem.imemRespValid ? S_REQ : S_DROP;
        else if (imem.imemRespValid) w_next_state = S_REQ;
      end
      S_DROP: if (imem.imemRespValid) w_next_state = S_REQ;
      default: w_next_state = S_REQ;
    endcase
  end

  always_comb begin
    imem.imemReqValid = 1'b0;
    imem.imemReqAddr  = r_fetch_pc;
    if (r_state == S_REQ && !w_skid_full && !reset) imem.imemReqValid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= RESET_PC;
      idValid     <= 1'b0;
      pc          <= RESET_PC;
      instruction <= NOP;
    end else if (redirect) begin
      // A request accepted this cycle is for the old path; the FSM drops it.
      r_fetch_pc  <= word_align(redirectPC);
      idValid     <= 1'b0;
      instruction <= NOP;
    end else begin
      if (w_handshake) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + WORD'(4);
      end
      if (w_skid_drain) begin
        idValid     <= 1'b1;
        pc          <= w_skid_entry.pc;
        instruction <= w_skid_entry.instr;
      end else if (w_deliver && (!stallIF || !idValid)) begin
        idValid     <= 1'b1;
        pc          <= r_req_pc;
        instruction <= imem.imemRespData;
      end else if (!stallIF) begin
        idValid     <= 1'b0;
        instruction <= NOP;
      end
    end
  end

  // Only one request may be outstanding, so a response in S_REQ is illegal.
  a_no_resp_in_req: assert property (@(posedge clk) disable iff (reset)
    !(r_state == S_REQ && imem.imemRespValid));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle tables plus hand sequences, a latency-
// programmable memory model and request/IF-ID scoreboards.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = '0;
  logic        stallIF = 1'b0;
  logic        idValid;
  logic [31:0] pc;
  logic [31:0] instruction;

  fetch_stage_if imem_if ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .stallIF     (stallIF),
    .imem        (imem_if.master),
    .idValid     (idValid),
    .pc          (pc),
    .instruction (instruction)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_lat = 1;

  logic [31:0]  exp_req_q[$];
  fetch_entry_t exp_id_q[$];

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          ready;
    bit          exp_rv;
    logic [31:0] exp_ra;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t t1[7];
  vec_t t2[10];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(bit st, bit rd, logic [31:0] rpc, bit rdy,
                              bit rv, logic [31:0] ra, bit iv, logic [31:0] epc);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.ready = rdy;
    v.exp_rv = rv; v.exp_ra = ra; v.exp_iv = iv; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_id(input logic [31:0] a);
    exp_id_q.push_back('{pc: a, instr: mem_data(a)});
  endtask

  // Memory model: samples the handshake at the edge, responds resp_lat cycles later.
  logic        s_hs, s_rst, pending = 1'b0;
  logic [31:0] s_addr, paddr;
  int          countdown;
  initial begin
    imem_if.imemReqReady  = 1'b1;
    imem_if.imemRespValid = 1'b0;
    imem_if.imemRespData  = '0;
  end
  always begin
    @(posedge clk);
    s_hs   = imem_if.imemReqValid && imem_if.imemReqReady;
    s_addr = imem_if.imemReqAddr;
    s_rst  = reset;
    #2;
    imem_if.imemRespValid = 1'b0;
    if (s_rst) begin
      pending = 1'b0;
    end else begin
      if (s_hs) begin
        if (exp_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_extra: got addr=%h want no request at %0t", s_addr, $time);
        end else begin
          check("req_addr", s_addr, exp_req_q.pop_front());
        end
        pending = 1'b1; countdown = resp_lat; paddr = s_addr;
      end
      if (pending) begin
        countdown--;
        if (countdown == 0) begin
          imem_if.imemRespValid = 1'b1;
          imem_if.imemRespData  = mem_data(paddr);
          pending = 1'b0;
        end
      end
    end
  end

  // ID consumes IF/ID on every unstalled cycle where it holds a valid instruction.
  always @(negedge clk) begin
    if (!reset && idValid && !stallIF) begin
      if (exp_id_q.size() == 0) begin
        total++; bad++;
        $display("FAIL id_extra: got pc=%h want nothing at %0t", pc, $time);
      end else begin
        fetch_entry_t e;
        e = exp_id_q.pop_front();
        check("id_pc", pc, e.pc);
        check("id_instr", instruction, e.instr);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    reset = 1'b0;
    stallIF = v.stall;
    redirect = v.redir;
    redirectPC = v.rpc;
    imem_if.imemReqReady = v.ready;
    @(negedge clk);
    check({tag, "_reqvalid"}, 32'(imem_if.imemReqValid), 32'(v.exp_rv));
    if (v.exp_rv) check({tag, "_reqaddr"}, imem_if.imemReqAddr, v.exp_ra);
    check({tag, "_idvalid"}, 32'(idValid), 32'(v.exp_iv));
    if (v.exp_iv) begin
      check({tag, "_pc"}, pc, v.exp_pc);
      check({tag, "_instr"}, instruction, mem_data(v.exp_pc));
    end else begin
      check({tag, "_nop"}, instruction, 32'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; stallIF = 1'b0; redirect = 1'b0; redirectPC = '0;
    imem_if.imemReqReady = 1'b1; resp_lat = 1;
    exp_req_q.delete(); exp_id_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_reqvalid", 32'(imem_if.imemReqValid), 32'h0);
    check("rst_idvalid", 32'(idValid), 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
  endtask

  task automatic end_test(input string tag);
    @(posedge clk); #1;
    stallIF = 1'b0; redirect = 1'b0; imem_if.imemReqReady = 1'b0;
    @(negedge clk); #1;
    check({tag, "_req_left"}, 32'(exp_req_q.size()), 32'h0);
    check({tag, "_id_left"}, 32'(exp_id_q.size()), 32'h0);
  endtask

  initial begin
    // Streaming with zero-wait memory: one instruction every two cycles.
    t1[0] = mk(0, 0, 0, 1, 1, 32'h0, 0, 0);
    t1[1] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    t1[2] = mk(0, 0, 0, 1, 1, 32'h4, 1, 32'h0);
    t1[3] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    t1[4] = mk(0, 0, 0, 1, 1, 32'h8, 1, 32'h4);
    t1[5] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    t1[6] = mk(0, 0, 0, 0, 1, 32'hC, 1, 32'h8);

    // Four-cycle stall: response for 0x4 lands in the skid buffer.
    t2[0] = mk(0, 0, 0, 1, 1, 32'h0, 0, 0);
    t2[1] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    t2[2] = mk(1, 0, 0, 1, 1, 32'h4, 1, 32'h0);
    t2[3] = mk(1, 0, 0, 1, 0, 0, 1, 32'h0);
    t2[4] = mk(1, 0, 0, 1, 0, 0, 1, 32'h0);
    t2[5] = mk(1, 0, 0, 1, 0, 0, 1, 32'h0);
    t2[6] = mk(0, 0, 0, 1, 0, 0, 1, 32'h0);
    t2[7] = mk(0, 0, 0, 1, 1, 32'h8, 1, 32'h4);
    t2[8] = mk(0, 0, 0, 1, 0, 0, 0, 0);
    t2[9] = mk(0, 0, 0, 0, 1, 32'hC, 1, 32'h8);

    do_reset();
    exp_req_q = '{32'h0, 32'h4, 32'h8};
    push_id(32'h0); push_id(32'h4); push_id(32'h8);
    for (int i = 0; i < 7; i++) run_vec(t1[i], "stream");
    end_test("stream");

    do_reset();
    exp_req_q = '{32'h0, 32'h4, 32'h8};
    push_id(32'h0); push_id(32'h4); push_id(32'h8);
    for (int i = 0; i < 10; i++) run_vec(t2[i], "stall");
    end_test("stall");

    // Redirect in S_WAIT; the stale response shows up two cycles later.
    do_reset();
    resp_lat = 3;
    exp_req_q = '{32'h0, 32'h1000};
    push_id(32'h1000);
    run_vec(mk(0, 0, 0,            1, 1, 32'h0,    0, 0), "rdwait");
    run_vec(mk(0, 1, 32'h0000_1003, 1, 0, 0,        0, 0), "rdwait");
    run_vec(mk(0, 0, 0,            1, 0, 0,        0, 0), "rdwait");
    run_vec(mk(0, 0, 0,            1, 0, 0,        0, 0), "rdwait");
    resp_lat = 1;
    run_vec(mk(0, 0, 0,            1, 1, 32'h1000, 0, 0), "rdwait");
    run_vec(mk(0, 0, 0,            1, 0, 0,        0, 0), "rdwait");
    run_vec(mk(0, 0, 0,            0, 1, 32'h1004, 1, 32'h1000), "rdwait");
    end_test("rdwait");

    // Redirect in the very cycle the response arrives.
    do_reset();
    exp_req_q = '{32'h0, 32'h2000};
    push_id(32'h2000);
    run_vec(mk(0, 0, 0,       1, 1, 32'h0,    0, 0), "rdresp");
    run_vec(mk(0, 1, 32'h2000, 1, 0, 0,        0, 0), "rdresp");
    run_vec(mk(0, 0, 0,       1, 1, 32'h2000, 0, 0), "rdresp");
    run_vec(mk(0, 0, 0,       1, 0, 0,        0, 0), "rdresp");
    run_vec(mk(0, 0, 0,       0, 1, 32'h2004, 1, 32'h2000), "rdresp");
    end_test("rdresp");

    // Redirect while stalled with a full skid buffer.
    do_reset();
    exp_req_q = '{32'h0, 32'h4, 32'h3000};
    push_id(32'h3000);
    for (int i = 0; i < 5; i++) run_vec(t2[i], "rdskid");
    run_vec(mk(1, 1, 32'h3000, 1, 0, 0,        1, 32'h0), "rdskid");
    run_vec(mk(1, 0, 0,        1, 1, 32'h3000, 0, 0), "rdskid");
    run_vec(mk(1, 0, 0,        1, 0, 0,        0, 0), "rdskid");
    run_vec(mk(0, 0, 0,        0, 1, 32'h3004, 1, 32'h3000), "rdskid");
    end_test("rdskid");

    // Fetch PC wraps from the top word back to zero.
    do_reset();
    exp_req_q = '{32'hFFFF_FFFC};
    push_id(32'hFFFF_FFFC);
    run_vec(mk(0, 1, 32'hFFFF_FFFF, 0, 1, 32'h0,         0, 0), "wrap");
    run_vec(mk(0, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 0), "wrap");
    run_vec(mk(0, 0, 0,             1, 0, 0,             0, 0), "wrap");
    run_vec(mk(0, 0, 0,             0, 1, 32'h0,         1, 32'hFFFF_FFFC), "wrap");
    end_test("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the fetch PC and issues one-at-a-time requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Delivers {pc, instruction, idValid} to the IF/ID boundary. Honours ID-stage stalls and applies redirects (taken branch, jump-register, jump) from the next-PC logic, which consumes pc/instruction from this block.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- redirect  in  1  discard in-flight/buffered fetches and restart at redirectPC.
- redirectPC  in  32  new fetch address; bits [1:0] ignored (forced 0).
- stallIF  in  1  ID cannot accept; IF/ID outputs must hold.
- imemReqValid  out  1  request valid.
- imemReqAddr  out  32  word-aligned fetch address.
- imemReqReady  in  1  memory accepts request this cycle.
- imemRespValid  in  1  response data valid (exactly one per accepted request, latency >= 1).
- imemRespData  in  32  fetched instruction.
- idValid  out  1  IF/ID holds a real instruction.
- pc  out  32  address of instruction in IF/ID.
- instruction  out  32  IF/ID instruction; 32'h0000_0000 (NOP) when idValid=0.

Behaviour:
- Reset: synchronous, active-high; fetchPC=RESET_PC, state=S_REQ, idValid=0, pc=RESET_PC, instruction=0, skid buffer empty. imemReqValid=0 in the reset cycle and 1 from the first cycle after reset deasserts. Reset mid-transaction: any outstanding response is ignored until the state machine has returned to S_REQ. The memory side must be reset in the same cycle.
- State machine:
  - S_REQ: imemReqValid=1 only when the skid buffer is empty; imemReqAddr=fetchPC. On handshake: reqPC<=fetchPC, fetchPC<=fetchPC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go S_WAIT.
  - S_WAIT: imemReqValid=0. On imemRespValid, deliver {reqPC, imemRespData} and go S_REQ.
  - S_DROP: imemReqValid=0. On imemRespValid, discard the response and go S_REQ.
- Delivery: if IF/ID is empty or stallIF=0, the response loads IF/ID the next cycle (idValid=1). Otherwise it loads the one-entry skid buffer.
- Skid buffer: drains into IF/ID on the first cycle with stallIF=0. No new request issues while it is full.
- Stall: while stallIF=1, pc, instruction and idValid are unchanged. When stallIF=0 and nothing is delivered, idValid<=0 (bubble).
- Redirect has priority over stall, delivery and request. In the redirect cycle:
  - fetchPC<=redirectPC&~3, idValid<=0, instruction<=0, skid buffer cleared.
  - S_REQ with handshake this cycle: the old-address request is already accepted, so go S_DROP.
  - S_REQ without handshake: stay in S_REQ; next request uses the new address.
  - S_WAIT with imemRespValid this cycle: discard the response, go S_REQ.
  - S_WAIT without a response: go S_DROP.
  - S_DROP: stay in S_DROP; if imemRespValid this cycle, go S_REQ.
- Redirect latency: the first request at redirectPC is visible the cycle after redirect, or after the drop completes. With zero-wait memory (response the cycle after request), throughput is one instruction per 2 cycles.
- At most one request outstanding. A response arriving in S_REQ is a protocol violation; assert it in simulation.

Decomposition:
- Shared include/package, alongside the existing ISA definitions:
  - WORD width macro.
  - NOP encoding (32'h0).
  - Fetch state encodings S_REQ=2'd0, S_WAIT=2'd1, S_DROP=2'd2.
  - Default RESET_PC.
- Sub-module: fetch_skid_buffer, a one-entry {pc, instruction} holding register with load/drain/clear and a full flag.

Test Plan:
- Reset released, memory always ready, response 1 cycle after request → requests at 0x0, 0x4, 0x8; IF/ID shows pc=0x0 with memory data, then pc=0x4; idValid pulses every other cycle.
- stallIF=1 for 4 cycles while IF/ID is full and a response arrives → IF/ID holds; response goes to the skid buffer; no new request; on stall release the buffered pc=0x4 appears, then requests resume at 0x8.
- Redirect to 0x0000_1003 while in S_WAIT, response arrives 2 cycles later → response discarded, idValid=0; next request addr=0x0000_1000.
- Redirect in the same cycle as imemRespValid in S_WAIT → data not delivered; next-cycle request addr=redirectPC.
- Redirect together with stallIF=1 and a full skid buffer → idValid=0 and buffer empty next cycle; fetch restarts at the new address.
- fetchPC=0xFFFF_FFFC accepted → next request addr=0x0000_0000.
